rx_uart: RTL and testbench
==========================

// Module: rx_uart
// PURPOSE
// - UART receiver stage sitting directly downstream of tx_uart's serial_out (loopback / board RX pin).
// - Recovers 11-bit frames (start 0, 8 data LSB-first, parity, stop 1) by oversampling on baud_clk.
// - Presents the byte on parallel_out with parity and framing status for the MIPS-side consumer.
// PARAMETERS
// - OVERSAMPLE  16  baud_clk cycles per bit; even, 4..256; tick counter is 8 bits wide.
// PORTS
// - baud_clk      in   1  single clock, OVERSAMPLE x bit rate.
// - rst           in   1  asynchronous, active-high reset.
// - serial_in     in   1  line input, idle high; asynchronous to baud_clk.
// - Parity        in   1  0 = even, 1 = odd; expected bit = ^data ^ Parity (same rule as tx_uart).
// - parallel_out  out  8  last received byte.
// - data_valid    out  1  one-cycle strobe: new byte on parallel_out.
// - parity_err    out  1  parity mismatch for the byte flagged by data_valid.
// - frame_err     out  1  stop bit sampled 0 for the byte flagged by data_valid.
// - busy          out  1  high in every state except IDLE.
// BEHAVIOUR
// - Reset: state IDLE; counters 0; sync flops 1; parallel_out 8'h00; all status outputs 0.
// - serial_in passes a 2-flop synchronizer; all decisions use the second flop (rx_s).
// - States: IDLE, START, DATA, PAR, STOP.
//   IDLE:  rx_s == 0 -> START, tick counter cleared.
//   START: at tick OVERSAMPLE/2-1 (mid start bit), rx_s == 1 -> IDLE (glitch, no output);
//          else -> DATA, tick and bit counters cleared.
//   DATA:  every OVERSAMPLE ticks sample rx_s into shift[bit_cnt] (LSB first);
//          after bit 7 -> PAR.
//   PAR:   sample after OVERSAMPLE ticks; parity_err_next = sample ^ (^shift) ^ Parity -> STOP.
//   STOP:  sample after OVERSAMPLE ticks; load parallel_out <= shift, pulse data_valid for one cycle,
//          parity_err / frame_err update in the same cycle and hold until the next data_valid.
//          If the stop sample is 0 (frame_err) -> IDLE only once rx_s == 1 (break held: no re-trigger).
// - Latency: data_valid rises 2 cycles (sync) + 1 after the mid-stop-bit sample,
//   about 10.5 bit-times after the start edge.
// - Bytes are delivered even when parity_err or frame_err is set; the consumer decides.
// - A falling edge on serial_in while not IDLE is ignored; only the next IDLE detects a new start.
// - Back-to-back frames: STOP -> IDLE -> START with no dead bit-time required.
// - rst mid-frame: immediate abort, reset values, partial byte discarded, no data_valid.
// CONFIGURATION
// - RX_HOLD_EN defined: adds in port rd_ack (1) and out port overrun (1).
//   A holding register keeps data_valid high (level) from the load until rd_ack is seen high.
//   data_valid drops on the cycle after rd_ack.
//   If a new byte completes while data_valid is still high:
//   - parallel_out is overwritten and overrun is set (sticky until rd_ack).
//   - Simultaneous rd_ack and completion: the new byte wins, data_valid stays high,
//     and overrun is not set.
// - RX_HOLD_EN undefined: data_valid is a one-cycle pulse; no rd_ack or overrun ports; no holding logic.
// TESTING
// - Reset, serial_in=1 for 100 cycles -> outputs 0, busy 0, no data_valid.
// - Parity=0, frame 0x55 (parity bit 0), OVERSAMPLE=16 -> one data_valid,
//   parallel_out=8'h55, parity_err=0, frame_err=0.
// - Parity=1, frame 0xA3 with parity bit 0 (wrong) -> parallel_out=8'hA3, parity_err=1.
// - Frame 0x0F with stop bit 0, line low 3 bit-times -> frame_err=1, busy until line returns high,
//   then no extra byte.
// - 0->1 glitch of 4 cycles in IDLE -> return to IDLE, no data_valid.
//   rst pulsed in DATA bit 3 -> reset values, no data_valid.
// - tx_uart loopback with bytes 0x00, 0xFF, 0x81 sent back-to-back -> three bytes in order, no errors.
//   With RX_HOLD_EN and rd_ack held low, overrun=1 after the second byte and parallel_out=8'h81 at the end.

Source files
------------

// File: rtl/rx_uart.sv
// rx_uart: oversampling UART receiver for 11-bit frames made of a start bit (0), eight data bits
// sent LSB first, a parity bit and a stop bit (1).
// The received byte appears on parallel_out together with its parity and framing status.
// Optional feature macro: RX_HOLD_EN. When it is defined, a holding register keeps data_valid
// high until the consumer raises rd_ack, and an overrun flag reports bytes that were overwritten
// before they were read.

module rx_uart #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       baud_clk,
  input  logic       rst,
  input  logic       serial_in,
  input  logic       Parity,
`ifdef RX_HOLD_EN
  input  logic       rd_ack,
  output logic       overrun,
`endif
  output logic [7:0] parallel_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  // Tick values at which the line is sampled: the middle of the start bit, and one full bit
  // period later for every following bit.
  localparam logic [7:0] TickMid  = 8'(OVERSAMPLE / 2 - 1);
  localparam logic [7:0] TickLast = 8'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StPar,
    StStop
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       par_err_q, par_err_d;
  // Set after a stop bit sampled low; the FSM stays in StStop until the line goes high again.
  logic       wait_high_q, wait_high_d;

  logic       rx_meta_q, rx_s_q;

  logic       load;
  logic       load_fe;

  logic [7:0] out_q;
  logic       dv_q, dv_d;
  logic       pe_q;
  logic       fe_q;

  // Two-flop synchronizer for the asynchronous line. It resets to the idle level so that
  // leaving reset cannot be mistaken for a start edge.
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= serial_in;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Registers for the FSM state and the frame datapath.
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      par_err_q   <= 1'b0;
      wait_high_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      par_err_q   <= par_err_d;
      wait_high_q <= wait_high_d;
    end
  end

  // Next state: walk the frame, sampling the line once per bit period.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_err_d   = par_err_q;
    wait_high_d = wait_high_q;
    load        = 1'b0;
    load_fe     = 1'b0;

    case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          tick_d  = '0;
        end
      end

      StStart: begin
        if (tick_q == TickMid) begin
          if (rx_s_q) begin
            // The line is high again at mid start bit, so the edge was only a glitch.
            state_d = StIdle;
          end else begin
            state_d = StData;
            tick_d  = '0;
            bit_d   = '0;
          end
        end else begin
          tick_d = tick_q + 8'd1;
        end
      end

      StData: begin
        if (tick_q == TickLast) begin
          tick_d          = '0;
          shift_d[bit_q]  = rx_s_q;
          bit_d           = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = StPar;
          end
        end else begin
          tick_d = tick_q + 8'd1;
        end
      end

      StPar: begin
        if (tick_q == TickLast) begin
          tick_d    = '0;
          // The expected bit is ^data ^ Parity; any difference from the sample is an error.
          par_err_d = rx_s_q ^ (^shift_q) ^ Parity;
          state_d   = StStop;
        end else begin
          tick_d = tick_q + 8'd1;
        end
      end

      StStop: begin
        if (wait_high_q) begin
          if (rx_s_q) begin
            wait_high_d = 1'b0;
            state_d     = StIdle;
          end
        end else if (tick_q == TickLast) begin
          tick_d  = '0;
          load    = 1'b1;
          load_fe = ~rx_s_q;
          if (rx_s_q) begin
            state_d = StIdle;
          end else begin
            // The line is held low (a break). Wait for it to go high so that the same low
            // level is not taken as a new start bit.
            wait_high_d = 1'b1;
          end
        end else begin
          tick_d = tick_q + 8'd1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

`ifdef RX_HOLD_EN
  logic ovr_q, ovr_d;

  // Holding register handshake. data_valid stays high until rd_ack is seen. When a new byte
  // arrives in the same cycle as rd_ack, the new byte takes over without an overrun.
  always_comb begin
    dv_d  = dv_q;
    ovr_d = ovr_q;
    if (load) begin
      dv_d  = 1'b1;
      ovr_d = (ovr_q | dv_q) & ~rd_ack;
    end else if (rd_ack) begin
      dv_d  = 1'b0;
      ovr_d = 1'b0;
    end
  end

  // Overrun flag register.
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign overrun = ovr_q;
`else
  // Without the holding register, data_valid is a one-cycle strobe.
  always_comb begin
    dv_d = load;
  end
`endif

  // Output registers. The byte and its status are loaded together and held until the next load.
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      out_q <= 8'h00;
      dv_q  <= 1'b0;
      pe_q  <= 1'b0;
      fe_q  <= 1'b0;
    end else begin
      dv_q <= dv_d;
      if (load) begin
        out_q <= shift_q;
        pe_q  <= par_err_q;
        fe_q  <= load_fe;
      end
    end
  end

  assign parallel_out = out_q;
  assign data_valid   = dv_q;
  assign parity_err   = pe_q;
  assign frame_err    = fe_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_rx_uart.sv
// tb_rx_uart: self-checking bench for rx_uart. It builds serial frames bit by bit and predicts
// each received byte and its status from the frame contents.
// It compiles with or without RX_HOLD_EN.

module tb_rx_uart;

  localparam int unsigned OS = 16;

  logic       baud_clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial_in = 1'b1;
  logic       Parity = 1'b0;
  logic [7:0] parallel_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;
`ifdef RX_HOLD_EN
  logic       rd_ack = 1'b0;
  logic       overrun;
  logic       auto_ack = 1'b1;
  logic       manual_ack = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Each entry is {frame_err, parity_err, byte}.
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];

  always #5 baud_clk = ~baud_clk;

  rx_uart #(
    .OVERSAMPLE(OS)
  ) dut (
    .baud_clk    (baud_clk),
    .rst         (rst),
    .serial_in   (serial_in),
    .Parity      (Parity),
`ifdef RX_HOLD_EN
    .rd_ack      (rd_ack),
    .overrun     (overrun),
`endif
    .parallel_out(parallel_out),
    .data_valid  (data_valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  // Record every delivered byte. In hold mode, each byte is also acknowledged once.
  always @(negedge baud_clk) begin
`ifdef RX_HOLD_EN
    if (auto_ack) begin
      if (!rst && data_valid && !rd_ack) begin
        got_q.push_back({frame_err, parity_err, parallel_out});
        rd_ack = 1'b1;
      end else begin
        rd_ack = 1'b0;
      end
    end else begin
      rd_ack = manual_ack;
    end
`else
    if (!rst && data_valid) begin
      got_q.push_back({frame_err, parity_err, parallel_out});
    end
`endif
  end

  // Reference model: predicts the status from the frame contents.
  function automatic logic [9:0] model(input logic [7:0] d, input logic par,
                                       input logic pbit, input logic stop);
    int   ones;
    logic want;
    ones = $countones(d);
    want = ((ones % 2) == 1) ^ par;
    return {~stop, (pbit != want), d};
  endfunction

  function automatic logic good_parity(input logic [7:0] d, input logic par);
    return (($countones(d) % 2) == 1) ^ par;
  endfunction

  task automatic drive_bit(input logic b);
    serial_in = b;
    repeat (OS) @(negedge baud_clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(pbit);
    drive_bit(stop);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (4) @(negedge baud_clk);
    vectors++;
    if ({parallel_out, data_valid, parity_err, frame_err, busy} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_in: got %h expected 000",
               {parallel_out, data_valid, parity_err, frame_err, busy});
    end
    rst = 1'b0;
    repeat (100) @(negedge baud_clk);
    vectors++;
    if ({parallel_out, data_valid, parity_err, frame_err, busy} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_idle: got %h expected 000",
               {parallel_out, data_valid, parity_err, frame_err, busy});
    end
    vectors++;
    if (got_q.size() !== 0) begin
      miscompares++;
      $display("FAIL reset_no_dv: got %0d bytes expected 0", got_q.size());
    end
`ifdef RX_HOLD_EN
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_overrun: got %b expected 0", overrun);
    end
`endif
  endtask

  task automatic test_directed;
    Parity = 1'b0;
    send_frame(8'h55, 1'b0, 1'b1);
    drive_bit(1'b1);
    vectors++;
    if (got_q.size() !== 1) begin
      miscompares++;
      $display("FAIL byte55_count: got %0d expected 1", got_q.size());
    end else begin
      vectors++;
      if (got_q[0] !== {2'b00, 8'h55}) begin
        miscompares++;
        $display("FAIL byte55: got %h expected %h", got_q[0], {2'b00, 8'h55});
      end
    end
    got_q.delete();
    Parity = 1'b1;
    send_frame(8'hA3, 1'b0, 1'b1);
    drive_bit(1'b1);
    vectors++;
    if (got_q.size() !== 1) begin
      miscompares++;
      $display("FAIL byteA3_count: got %0d expected 1", got_q.size());
    end else begin
      vectors++;
      if (got_q[0] !== {2'b01, 8'hA3}) begin
        miscompares++;
        $display("FAIL byteA3_parity: got %h expected %h", got_q[0], {2'b01, 8'hA3});
      end
    end
    got_q.delete();
  endtask

  task automatic test_break;
    Parity = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(i < 4);
    drive_bit(1'b0);
    repeat (3) drive_bit(1'b0);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL break_busy: got %b expected 1", busy);
    end
    vectors++;
    if (got_q.size() !== 1 || got_q[0] !== {2'b10, 8'h0F}) begin
      miscompares++;
      $display("FAIL break_byte: got %0d bytes first %h expected 1 bytes %h",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 10'h0, {2'b10, 8'h0F});
    end
    serial_in = 1'b1;
    repeat (2 * OS) @(negedge baud_clk);
    vectors++;
    if (busy !== 1'b0 || got_q.size() !== 1) begin
      miscompares++;
      $display("FAIL break_release: got busy %b bytes %0d expected busy 0 bytes 1",
               busy, got_q.size());
    end
    got_q.delete();
  endtask

  task automatic test_glitch;
    serial_in = 1'b0;
    repeat (4) @(negedge baud_clk);
    serial_in = 1'b1;
    repeat (2 * OS) @(negedge baud_clk);
    vectors++;
    if (busy !== 1'b0 || got_q.size() !== 0 || parallel_out !== 8'h0F) begin
      miscompares++;
      $display("FAIL glitch: got busy %b bytes %0d out %h expected busy 0 bytes 0 out 0f",
               busy, got_q.size(), parallel_out);
    end
  endtask

  task automatic test_rst_mid;
    logic [7:0] d;
    d = 8'hA5;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    serial_in = d[3];
    repeat (OS / 2) @(negedge baud_clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_busy_before: got %b expected 1", busy);
    end
    rst = 1'b1;
    repeat (3) @(negedge baud_clk);
    vectors++;
    if ({parallel_out, data_valid, parity_err, frame_err, busy} !== 12'h000) begin
      miscompares++;
      $display("FAIL rstmid_values: got %h expected 000",
               {parallel_out, data_valid, parity_err, frame_err, busy});
    end
    rst = 1'b0;
    serial_in = 1'b1;
    repeat (3 * OS) @(negedge baud_clk);
    vectors++;
    if (busy !== 1'b0 || got_q.size() !== 0) begin
      miscompares++;
      $display("FAIL rstmid_after: got busy %b bytes %0d expected busy 0 bytes 0",
               busy, got_q.size());
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [3];
    bytes[0] = 8'h00;
    bytes[1] = 8'hFF;
    bytes[2] = 8'h81;
    Parity = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_frame(bytes[i], good_parity(bytes[i], Parity), 1'b1);
      exp_q.push_back({2'b00, bytes[i]});
    end
    drive_bit(1'b1);
    vectors++;
    if (got_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL b2b_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random;
    logic [7:0] d;
    logic       pbit;
    logic       stop;
    int         gap;
    for (int n = 0; n < 40; n++) begin
      d      = 8'($urandom);
      Parity = 1'($urandom);
      pbit   = good_parity(d, Parity) ^ ($urandom_range(0, 3) == 0);
      stop   = ($urandom_range(0, 7) != 0);
      gap    = $urandom_range(0, 2);
      if (!stop && gap == 0) gap = 1;
      send_frame(d, pbit, stop);
      exp_q.push_back(model(d, Parity, pbit, stop));
      for (int g = 0; g < gap; g++) drive_bit(1'b1);
    end
    drive_bit(1'b1);
    drive_bit(1'b1);
    vectors++;
    if (got_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL rand_frame%0d: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

`ifdef RX_HOLD_EN
  task automatic test_overrun;
    logic [7:0] bytes [3];
    bytes[0] = 8'h00;
    bytes[1] = 8'hFF;
    bytes[2] = 8'h81;
    auto_ack = 1'b0;
    manual_ack = 1'b0;
    Parity = 1'b0;
    for (int i = 0; i < 3; i++) send_frame(bytes[i], good_parity(bytes[i], Parity), 1'b1);
    drive_bit(1'b1);
    vectors++;
    if ({data_valid, overrun, parallel_out} !== {2'b11, 8'h81}) begin
      miscompares++;
      $display("FAIL overrun_set: got %h expected %h",
               {data_valid, overrun, parallel_out}, {2'b11, 8'h81});
    end
    @(posedge baud_clk);
    #1 manual_ack = 1'b1;
    @(posedge baud_clk);
    #1 manual_ack = 1'b0;
    repeat (3) @(negedge baud_clk);
    vectors++;
    if ({data_valid, overrun} !== 2'b00) begin
      miscompares++;
      $display("FAIL overrun_ack: got %b expected 00", {data_valid, overrun});
    end
    auto_ack = 1'b1;
  endtask
`endif

  initial begin
    @(negedge baud_clk);
    test_reset();
    test_directed();
    test_break();
    test_glitch();
    test_rst_mid();
    test_back_to_back();
    test_random();
`ifdef RX_HOLD_EN
    test_overrun();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
